// File: rtl/ntt_output_reorder.sv
// rtl/ntt_output_reorder.sv - bit-reversed to natural order ping-pong frame reorder buffer
// Optional out_last output is enabled by defining NTT_REORDER_LAST_EN.
module ntt_output_reorder #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 32,
  parameter int LOG_LANES  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] inData_0,  inData_1,  inData_2,  inData_3,
                                inData_4,  inData_5,  inData_6,  inData_7,
                                inData_8,  inData_9,  inData_10, inData_11,
                                inData_12, inData_13, inData_14, inData_15,
                                inData_16, inData_17, inData_18, inData_19,
                                inData_20, inData_21, inData_22, inData_23,
                                inData_24, inData_25, inData_26, inData_27,
                                inData_28, inData_29, inData_30, inData_31,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] outData_0,  outData_1,  outData_2,  outData_3,
                                outData_4,  outData_5,  outData_6,  outData_7,
                                outData_8,  outData_9,  outData_10, outData_11,
                                outData_12, outData_13, outData_14, outData_15,
                                outData_16, outData_17, outData_18, outData_19,
                                outData_20, outData_21, outData_22, outData_23,
                                outData_24, outData_25, outData_26, outData_27,
                                outData_28, outData_29, outData_30, outData_31,
  output logic                  out_valid,
`ifdef NTT_REORDER_LAST_EN
  output logic                  out_last,
`endif
  input  logic                  out_ready
);

  localparam logic [LOG_LANES-1:0] LAST_BEAT = LOG_LANES'(LANES - 1);

  logic [LANES-1:0][DATA_WIDTH-1:0] in_lanes;
  logic [DATA_WIDTH-1:0]            bank_q [2][LANES][LANES];
  logic [1:0]                       full_q, full_d;
  logic                             wb_q, wb_d, rb_q, rb_d;
  logic [LOG_LANES-1:0]             wc_q, wc_d, rc_q, rc_d;
  logic                             out_valid_q, out_valid_d;
  logic [LANES-1:0][DATA_WIDTH-1:0] out_q, out_d;
  logic                             accept, load;
`ifdef NTT_REORDER_LAST_EN
  logic                             last_q, last_d;
`endif

  function automatic logic [LOG_LANES-1:0] bitrev(input logic [LOG_LANES-1:0] v);
    logic [LOG_LANES-1:0] r;
    for (int k = 0; k < LOG_LANES; k++) r[k] = v[LOG_LANES-1-k];
    return r;
  endfunction

  assign in_lanes = {inData_31, inData_30, inData_29, inData_28, inData_27, inData_26,
                     inData_25, inData_24, inData_23, inData_22, inData_21, inData_20,
                     inData_19, inData_18, inData_17, inData_16, inData_15, inData_14,
                     inData_13, inData_12, inData_11, inData_10, inData_9,  inData_8,
                     inData_7,  inData_6,  inData_5,  inData_4,  inData_3,  inData_2,
                     inData_1,  inData_0};
  assign {outData_31, outData_30, outData_29, outData_28, outData_27, outData_26,
          outData_25, outData_24, outData_23, outData_22, outData_21, outData_20,
          outData_19, outData_18, outData_17, outData_16, outData_15, outData_14,
          outData_13, outData_12, outData_11, outData_10, outData_9,  outData_8,
          outData_7,  outData_6,  outData_5,  outData_4,  outData_3,  outData_2,
          outData_1,  outData_0} = out_q;

  assign out_valid = out_valid_q;
  assign in_ready  = !full_q[wb_q];
  assign accept    = in_valid && in_ready;
  assign load      = full_q[rb_q] && (!out_valid_q || out_ready);
`ifdef NTT_REORDER_LAST_EN
  assign out_last  = last_q;
`endif

  // Words land at their natural position, so the reader just replays rows.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int l = 0; l < LANES; l++)
        bank_q[wb_q][bitrev(LOG_LANES'(l))][bitrev(wc_q)] <= in_lanes[l];
    end
  end

  always_comb begin
    wc_d        = wc_q;
    wb_d        = wb_q;
    rc_d        = rc_q;
    rb_d        = rb_q;
    full_d      = full_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
`ifdef NTT_REORDER_LAST_EN
    last_d      = last_q;
`endif
    if (accept) begin
      wc_d = wc_q + LOG_LANES'(1);
      if (wc_q == LAST_BEAT) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
      end
    end
    // Set and clear never target the same flag: a set needs full[wb]==0, a clear full[rb]==1.
    if (load) begin
      for (int j = 0; j < LANES; j++) out_d[j] = bank_q[rb_q][rc_q][j];
      out_valid_d = 1'b1;
      rc_d        = rc_q + LOG_LANES'(1);
`ifdef NTT_REORDER_LAST_EN
      last_d      = (rc_q == LAST_BEAT);
`endif
      if (rc_q == LAST_BEAT) begin
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
`ifdef NTT_REORDER_LAST_EN
      last_d      = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wc_q        <= '0;
      wb_q        <= 1'b0;
      rc_q        <= '0;
      rb_q        <= 1'b0;
      full_q      <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
`ifdef NTT_REORDER_LAST_EN
      last_q      <= 1'b0;
`endif
    end else begin
      wc_q        <= wc_d;
      wb_q        <= wb_d;
      rc_q        <= rc_d;
      rb_q        <= rb_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
`ifdef NTT_REORDER_LAST_EN
      last_q      <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_ntt_output_reorder.sv
// tb/tb_ntt_output_reorder.sv - randomized self-checking bench for ntt_output_reorder
// Out_last checks are compiled in when NTT_REORDER_LAST_EN is defined.
module tb_ntt_output_reorder;
  localparam int FW = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [FW-1:0] in_bus = '0;
  wire  [FW-1:0] out_bus;
  wire           in_ready;
  wire           out_valid;
`ifdef NTT_REORDER_LAST_EN
  wire           out_last;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [FW-1:0] in_q [$];
  logic [FW-1:0] exp_q [$];
  logic [FW-1:0] cur_frame [32];
  int            cur_cnt = 0;

  always #5 clk = ~clk;

  ntt_output_reorder dut (
    .clk(clk), .rst(rst),
    .inData_0(in_bus[0*32+:32]),   .inData_1(in_bus[1*32+:32]),   .inData_2(in_bus[2*32+:32]),   .inData_3(in_bus[3*32+:32]),
    .inData_4(in_bus[4*32+:32]),   .inData_5(in_bus[5*32+:32]),   .inData_6(in_bus[6*32+:32]),   .inData_7(in_bus[7*32+:32]),
    .inData_8(in_bus[8*32+:32]),   .inData_9(in_bus[9*32+:32]),   .inData_10(in_bus[10*32+:32]), .inData_11(in_bus[11*32+:32]),
    .inData_12(in_bus[12*32+:32]), .inData_13(in_bus[13*32+:32]), .inData_14(in_bus[14*32+:32]), .inData_15(in_bus[15*32+:32]),
    .inData_16(in_bus[16*32+:32]), .inData_17(in_bus[17*32+:32]), .inData_18(in_bus[18*32+:32]), .inData_19(in_bus[19*32+:32]),
    .inData_20(in_bus[20*32+:32]), .inData_21(in_bus[21*32+:32]), .inData_22(in_bus[22*32+:32]), .inData_23(in_bus[23*32+:32]),
    .inData_24(in_bus[24*32+:32]), .inData_25(in_bus[25*32+:32]), .inData_26(in_bus[26*32+:32]), .inData_27(in_bus[27*32+:32]),
    .inData_28(in_bus[28*32+:32]), .inData_29(in_bus[29*32+:32]), .inData_30(in_bus[30*32+:32]), .inData_31(in_bus[31*32+:32]),
    .in_valid(in_valid), .in_ready(in_ready),
    .outData_0(out_bus[0*32+:32]),   .outData_1(out_bus[1*32+:32]),   .outData_2(out_bus[2*32+:32]),   .outData_3(out_bus[3*32+:32]),
    .outData_4(out_bus[4*32+:32]),   .outData_5(out_bus[5*32+:32]),   .outData_6(out_bus[6*32+:32]),   .outData_7(out_bus[7*32+:32]),
    .outData_8(out_bus[8*32+:32]),   .outData_9(out_bus[9*32+:32]),   .outData_10(out_bus[10*32+:32]), .outData_11(out_bus[11*32+:32]),
    .outData_12(out_bus[12*32+:32]), .outData_13(out_bus[13*32+:32]), .outData_14(out_bus[14*32+:32]), .outData_15(out_bus[15*32+:32]),
    .outData_16(out_bus[16*32+:32]), .outData_17(out_bus[17*32+:32]), .outData_18(out_bus[18*32+:32]), .outData_19(out_bus[19*32+:32]),
    .outData_20(out_bus[20*32+:32]), .outData_21(out_bus[21*32+:32]), .outData_22(out_bus[22*32+:32]), .outData_23(out_bus[23*32+:32]),
    .outData_24(out_bus[24*32+:32]), .outData_25(out_bus[25*32+:32]), .outData_26(out_bus[26*32+:32]), .outData_27(out_bus[27*32+:32]),
    .outData_28(out_bus[28*32+:32]), .outData_29(out_bus[29*32+:32]), .outData_30(out_bus[30*32+:32]), .outData_31(out_bus[31*32+:32]),
    .out_valid(out_valid),
`ifdef NTT_REORDER_LAST_EN
    .out_last(out_last),
`endif
    .out_ready(out_ready)
  );

  function automatic int bitrev10(input int v);
    int r = 0;
    for (int k = 0; k < 10; k++) if (v[k]) r |= (1 << (9 - k));
    return r;
  endfunction

  function automatic int first_diff(input logic [FW-1:0] a, input logic [FW-1:0] b);
    for (int k = 0; k < 32; k++) if (a[k*32+:32] !== b[k*32+:32]) return k;
    return 0;
  endfunction

  // Reference: word at bit-reversed index i goes to natural index bitrev10(i).
  task automatic model_accept(input logic [FW-1:0] beat);
    logic [31:0]   nat [1024];
    logic [FW-1:0] ob;
    cur_frame[cur_cnt] = beat;
    cur_cnt++;
    if (cur_cnt == 32) begin
      for (int i = 0; i < 1024; i++) nat[bitrev10(i)] = cur_frame[i / 32][(i % 32)*32+:32];
      for (int r = 0; r < 32; r++) begin
        for (int j = 0; j < 32; j++) ob[j*32+:32] = nat[r*32 + j];
        exp_q.push_back(ob);
      end
      cur_cnt = 0;
    end
  endtask

  task automatic gen_frame(input bit ident);
    logic [FW-1:0] b;
    for (int c = 0; c < 32; c++) begin
      for (int l = 0; l < 32; l++) b[l*32+:32] = ident ? 32'(bitrev10(c*32 + l)) : $urandom();
      in_q.push_back(b);
    end
  endtask

  task automatic model_clear();
    in_q.delete();
    exp_q.delete();
    cur_cnt = 0;
  endtask

  // Drives one cycle at the falling edge and reports what transfers on the next rising edge.
  task automatic cycle(input bit iv, input bit ordy, output bit in_acc, output bit in_stall,
                       output bit out_acc, output bit out_vld, output logic [FW-1:0] obs);
    @(negedge clk);
    in_valid  = iv && (in_q.size() > 0);
    in_bus    = in_valid ? in_q[0] : '0;
    out_ready = ordy;
    #1;
    in_acc   = in_valid && in_ready;
    in_stall = in_valid && !in_ready;
    out_acc  = out_valid && out_ready;
    out_vld  = out_valid;
    obs      = out_bus;
    if (in_acc) model_accept(in_q.pop_front());
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_bus !== '0) begin n_err++; $display("FAIL reset_out_data: lane0 got %h want 0", out_bus[31:0]); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL post_reset: in_ready %b out_valid %b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_identity();
    bit ia, is, oa, ov;
    logic [FW-1:0] obs, expb, tmp;
    int cyc = 0, last_in = -1, first_out = -1, rx = 0;
    gen_frame(1'b1);
    while (rx < 32 && cyc < 300) begin
      cycle(1'b1, 1'b1, ia, is, oa, ov, obs);
      cyc++;
      if (ia && in_q.size() == 0) last_in = cyc;
      if (ov && first_out < 0) first_out = cyc;
      if (oa) begin
        for (int j = 0; j < 32; j++) expb[j*32+:32] = 32'(rx*32 + j);
        if (exp_q.size() > 0) tmp = exp_q.pop_front();
        n_cmp++;
        if (obs !== expb) begin
          n_err++;
          $display("FAIL identity beat %0d lane %0d: got %h want %h", rx, first_diff(obs, expb),
                   obs[first_diff(obs, expb)*32+:32], expb[first_diff(obs, expb)*32+:32]);
        end
        rx++;
      end
    end
    n_cmp++; if (rx != 32) begin n_err++; $display("FAIL identity_count: got %0d beats want 32", rx); end
    n_cmp++; if (first_out - last_in != 2) begin
      n_err++; $display("FAIL identity_latency: out_valid at cycle %0d, last input %0d, want gap 2", first_out, last_in);
    end
  endtask

  task automatic test_back_to_back();
    bit ia, is, oa, ov;
    logic [FW-1:0] obs, expb;
    int cyc = 0, rx = 0, gaps = 0, stalls = 0, bad = 0;
    repeat (3) gen_frame(1'b0);
    while (rx < 96 && cyc < 500) begin
      cycle(1'b1, 1'b1, ia, is, oa, ov, obs);
      cyc++;
      if (is) stalls++;
      if (rx > 0 && !oa) gaps++;
      if (oa) begin
        expb = (exp_q.size() > 0) ? exp_q.pop_front() : ~obs;
        if (obs !== expb) bad++;
        rx++;
      end
    end
    n_cmp++; if (rx != 96) begin n_err++; $display("FAIL b2b_count: got %0d beats want 96", rx); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL b2b_data: %0d wrong beats want 0", bad); end
    n_cmp++; if (gaps != 0) begin n_err++; $display("FAIL b2b_gaps: %0d out_valid gaps want 0", gaps); end
    n_cmp++; if (stalls != 0) begin n_err++; $display("FAIL b2b_in_ready: %0d stalled cycles want 0", stalls); end
  endtask

  task automatic test_backpressure();
    bit ia, is, oa, ov;
    logic [FW-1:0] obs, expb;
    int acc = 0, stall_at = -1, unstable = 0, held = 0, rx = 0, cyc = 0, bad = 0;
    repeat (3) gen_frame(1'b0);
    for (int i = 0; i < 120; i++) begin
      cycle(1'b1, 1'b0, ia, is, oa, ov, obs);
      if (ia) acc++;
      if (is && stall_at < 0) stall_at = acc;
      if (ov) begin
        held++;
        if (exp_q.size() == 0 || obs !== exp_q[0]) unstable++;
      end
    end
    n_cmp++; if (stall_at != 64) begin n_err++; $display("FAIL bp_stall_point: in_ready dropped after %0d beats want 64", stall_at); end
    n_cmp++; if (acc != 64) begin n_err++; $display("FAIL bp_accepted: got %0d beats want 64", acc); end
    n_cmp++; if (held == 0 || unstable != 0) begin
      n_err++; $display("FAIL bp_hold: %0d valid cycles, %0d not frame1 beat0, want >0 and 0", held, unstable);
    end
    while (rx < 96 && cyc < 600) begin
      cycle(1'b1, 1'b1, ia, is, oa, ov, obs);
      cyc++;
      if (oa) begin
        expb = (exp_q.size() > 0) ? exp_q.pop_front() : ~obs;
        if (obs !== expb) bad++;
        rx++;
      end
    end
    n_cmp++; if (rx != 96 || bad != 0) begin n_err++; $display("FAIL bp_drain: got %0d beats %0d wrong want 96 0", rx, bad); end
  endtask

  task automatic test_random_stall();
    bit ia, is, oa, ov;
    logic [FW-1:0] obs, expb;
    int rx = 0, cyc = 0, bad = 0;
    repeat (10) gen_frame(1'b0);
    while (rx < 320 && cyc < 8000) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ia, is, oa, ov, obs);
      cyc++;
      if (oa) begin
        expb = (exp_q.size() > 0) ? exp_q.pop_front() : ~obs;
        if (obs !== expb) begin
          bad++;
          if (bad < 4) $display("FAIL rand_data beat %0d lane %0d: got %h want %h", rx, first_diff(obs, expb),
                                obs[first_diff(obs, expb)*32+:32], expb[first_diff(obs, expb)*32+:32]);
        end
        rx++;
      end
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rand_total: %0d wrong beats want 0", bad); end
    n_cmp++; if (rx != 320 || exp_q.size() != 0) begin
      n_err++; $display("FAIL rand_count: got %0d beats, %0d left want 320 0", rx, exp_q.size());
    end
  endtask

  task automatic test_mid_frame_reset();
    bit ia, is, oa, ov;
    logic [FW-1:0] obs, expb;
    int acc = 0, rx = 0, cyc = 0, bad = 0;
    gen_frame(1'b0);
    while (acc < 17 && cyc < 100) begin
      cycle(1'b1, 1'b1, ia, is, oa, ov, obs);
      cyc++;
      if (ia) acc++;
    end
    @(negedge clk); in_valid = 1'b0; rst = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_in_mid: out_valid %b in_ready %b want 0 1", out_valid, in_ready);
    end
    @(posedge clk); @(negedge clk); rst = 1'b1;
    model_clear();
    gen_frame(1'b0);
    cyc = 0;
    while (rx < 5 && cyc < 200) begin
      cycle(1'b1, 1'b1, ia, is, oa, ov, obs);
      cyc++;
      if (oa) rx++;
    end
    @(negedge clk); in_valid = 1'b0; rst = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0 || out_bus !== '0) begin
      n_err++; $display("FAIL rst_out_mid: out_valid %b lane0 %h want 0 0", out_valid, out_bus[31:0]);
    end
    @(posedge clk); @(negedge clk); rst = 1'b1;
    model_clear();
    gen_frame(1'b0);
    rx = 0; cyc = 0;
    while (rx < 32 && cyc < 200) begin
      cycle(1'b1, 1'b1, ia, is, oa, ov, obs);
      cyc++;
      if (oa) begin
        expb = (exp_q.size() > 0) ? exp_q.pop_front() : ~obs;
        if (obs !== expb) bad++;
        rx++;
      end
    end
    n_cmp++; if (rx != 32 || bad != 0) begin n_err++; $display("FAIL rst_recover: got %0d beats %0d wrong want 32 0", rx, bad); end
  endtask

`ifdef NTT_REORDER_LAST_EN
  task automatic test_last();
    bit ia, is, oa, ov;
    logic [FW-1:0] obs, tmp;
    int rx = 0, cyc = 0, bad = 0, held31 = 0;
    repeat (2) gen_frame(1'b0);
    while (rx < 64 && cyc < 3000) begin
      cycle(1'b1, 1'($urandom_range(0, 1)), ia, is, oa, ov, obs);
      cyc++;
      if (ov) begin
        if (out_last !== (rx % 32 == 31)) bad++;
        if (!oa && rx % 32 == 31) held31++;
      end
      if (oa) begin
        if (exp_q.size() > 0) tmp = exp_q.pop_front();
        rx++;
      end
    end
    n_cmp++; if (bad != 0 || rx != 64) begin n_err++; $display("FAIL last_flag: %0d wrong cycles, %0d beats want 0 64", bad, rx); end
    n_cmp++; if (held31 == 0) begin n_err++; $display("FAIL last_hold: no stalled beat-31 cycle seen, got %0d want >0", held31); end
  endtask
`endif

  initial begin
    test_reset();
    test_identity();
    test_back_to_back();
    test_backpressure();
    test_random_stall();
    test_mid_frame_reset();
`ifdef NTT_REORDER_LAST_EN
    test_last();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
